mem_wait_ctrl: RTL

Parametrised memory-access stall controller for the RV32I datapath. It watches the current instruction opcode and freezes the PC and suppresses register write-back until the data memory access completes. It supports fixed load and store latencies, or a mem_ready handshake with a timeout. It sits beside ctrl_datapath and drives its pc_enable and reg_write_load nets, which are ANDed there with the decoder's reg_write.

---
 rtl/mem_wait_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl: stalls the RV32I datapath while a data memory access is in flight.
// It freezes the PC and blocks register write-back until the load or store completes.
// Completion comes from a fixed latency or from a mem_ready handshake with a timeout.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   opcode         inst[6:0] of the instruction at the current PC
//   mem_ready      data memory completion strobe (handshake mode only)
//   pc_enable      1: PC may load pc_next at the next edge
//   reg_write_load 1: register write-back permitted this cycle
//   mem_req        data memory access in progress
//   busy           FSM is in WAIT
//   wait_cnt       current counter value (0 in IDLE)
//   err_timeout    sticky handshake-timeout flag, cleared only by reset
module mem_wait_ctrl #(
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned STORE_LAT = 0,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned HANDSHAKE = 0,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_enable,
  output logic             reg_write_load,
  output logic             mem_req,
  output logic             busy,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             err_timeout
);

  localparam logic [6:0]       OP_LOAD  = 7'b0000011;
  localparam logic [6:0]       OP_STORE = 7'b0100011;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LOAD_N   = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] STORE_N  = CNT_W'(STORE_LAT);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             pc_c, rwl_c, req_c;
  logic             is_load, is_mem;
  logic [CNT_W-1:0] op_n;

  // Op decode; the latency is captured in the counter on leaving IDLE,
  // so later opcode changes cannot affect an access already in flight.
  assign is_load = (opcode == OP_LOAD);
  assign is_mem  = is_load || (opcode == OP_STORE);
  assign op_n    = is_load ? LOAD_N : STORE_N;

  // State, counter and sticky error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state and Mealy stall outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pc_c    = 1'b1;
    rwl_c   = 1'b1;
    req_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (is_mem) begin
          req_c = 1'b1;
          if (HANDSHAKE != 0) begin
            if (!mem_ready) begin
              pc_c    = 1'b0;
              rwl_c   = 1'b0;
              state_d = ST_WAIT;
            end
          end else if (op_n != '0) begin
            pc_c    = 1'b0;
            rwl_c   = 1'b0;
            state_d = ST_WAIT;
            cnt_d   = op_n - CNT_ONE;
          end
        end
      end
      ST_WAIT: begin
        req_c = 1'b1;
        if (HANDSHAKE != 0) begin
          if (mem_ready) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            // Forced completion: release the PC but drop the stale load data
            rwl_c   = 1'b0;
            err_d   = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            pc_c  = 1'b0;
            rwl_c = 1'b0;
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          end
        end else if (cnt_q != '0) begin
          pc_c  = 1'b0;
          rwl_c = 1'b0;
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Combinational outputs are forced low while reset is held
  assign pc_enable      = rst & pc_c;
  assign reg_write_load = rst & rwl_c;
  assign mem_req        = rst & req_c;
  assign busy           = (state_q == ST_WAIT);
  assign wait_cnt       = cnt_q;
  assign err_timeout    = err_q;

endmodule
